// File: rtl/toaplan2_snd_mailbox_if.sv
// Bus bundle between the 68k/sound-CPU glue and the sound command mailbox.
// The master side drives strobes, channel selects and masks; the slave returns data and status.
interface toaplan2_snd_mailbox_if #(
  parameter int CH = 2,
  parameter int DW = 8
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic           WR;
  logic [CHW-1:0] WR_CH;
  logic [DW-1:0]  WR_DATA;
  logic           RD;
  logic [CHW-1:0] RD_CH;
  logic [DW-1:0]  RD_DATA;
  logic [CH-1:0]  PENDING;
  logic [CH-1:0]  FULL;
  logic [CH-1:0]  OVF;
  logic [CH-1:0]  OVF_CLR;
  logic [CH-1:0]  IRQ_EN;
  logic           SND_IRQ;

  modport master (
    output WR, WR_CH, WR_DATA, RD, RD_CH, OVF_CLR, IRQ_EN,
    input  RD_DATA, PENDING, FULL, OVF, SND_IRQ
  );

  modport slave (
    input  WR, WR_CH, WR_DATA, RD, RD_CH, OVF_CLR, IRQ_EN,
    output RD_DATA, PENDING, FULL, OVF, SND_IRQ
  );
endinterface

// File: rtl/toaplan2_snd_mailbox.sv
// Main-CPU to sound-CPU command mailbox: CH channels, each a DEPTH-entry FIFO or an
// overwrite latch, with edge-detected level strobes, sticky overflow and a maskable IRQ.
module toaplan2_snd_mailbox #(
  parameter int CH        = 2,
  parameter int DEPTH     = 4,
  parameter int DW        = 8,
  parameter int FIFO_MODE = 1
) (
  input  logic                     CLK96,
  input  logic                     RESET96,
  toaplan2_snd_mailbox_if.slave    bus
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW  = $clog2(DEPTH);
  // Latch mode behaves like a one-deep queue with overwrite on push.
  localparam logic [AW:0]  FULL_LVL = (FIFO_MODE != 0) ? (AW+1)'(DEPTH) : (AW+1)'(1);
  localparam logic [CHW:0] CH_LIM   = (CHW+1)'(CH);

  logic           wr_q, rd_q;
  logic [DW-1:0]  mem_q [CH][DEPTH];
  logic [AW-1:0]  wptr_q [CH];
  logic [AW-1:0]  wptr_d [CH];
  logic [AW-1:0]  rptr_q [CH];
  logic [AW-1:0]  rptr_d [CH];
  logic [AW:0]    cnt_q  [CH];
  logic [AW:0]    cnt_d  [CH];
  logic [CH-1:0]  ovf_q, ovf_d;
  logic [CH-1:0]  pending_q, pending_d;
  logic [CH-1:0]  full_q, full_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic           irq_q;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic           push_ok, pop_ok;

  always_comb begin
    logic push_i, pop_i, do_push, do_pop;
    // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
    push_ok   = bus.WR & ~wr_q & ({1'b0, bus.WR_CH} < CH_LIM);
    pop_ok    = bus.RD & ~rd_q & ({1'b0, bus.RD_CH} < CH_LIM);
    rd_data_d = rd_data_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    ovf_d     = ovf_q & ~bus.OVF_CLR;
    for (int i = 0; i < CH; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      push_i    = push_ok && (bus.WR_CH == CHW'(i));
      pop_i     = pop_ok  && (bus.RD_CH == CHW'(i));
      if (FIFO_MODE != 0) begin
        // A pop at the same edge frees the slot, so a full channel still accepts the push.
        do_push = push_i && ((cnt_q[i] != FULL_LVL) || pop_i);
        do_pop  = pop_i && (cnt_q[i] != '0);
        if (push_i && !do_push) ovf_d[i] = 1'b1;
        if (do_push) begin
          mem_we    = 1'b1;
          mem_waddr = wptr_q[i];
          wptr_d[i] = wptr_q[i] + 1'b1;
        end
        if (do_pop) begin
          rd_data_d = mem_q[i][rptr_q[i]];
          rptr_d[i] = rptr_q[i] + 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
          2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
          default: cnt_d[i] = cnt_q[i];
        endcase
      end else begin
        if (push_i) begin
          mem_we   = 1'b1;
          cnt_d[i] = (AW+1)'(1);
          if ((cnt_q[i] != '0) && !pop_i) ovf_d[i] = 1'b1;
        end
        if (pop_i) begin
          rd_data_d = mem_q[i][0];
          if (!push_i) cnt_d[i] = '0;
        end
      end
      pending_d[i] = (cnt_d[i] != '0);
      full_d[i]    = (cnt_d[i] == FULL_LVL);
    end
  end

  // NOTE: the storage array has no reset; only pointers and counts define what is valid.
  always_ff @(posedge CLK96) begin
    if (mem_we) mem_q[bus.WR_CH][mem_waddr] <= bus.WR_DATA;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      ovf_q     <= '0;
      pending_q <= '0;
      full_q    <= '0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      wr_q      <= bus.WR;
      rd_q      <= bus.RD;
      ovf_q     <= ovf_d;
      pending_q <= pending_d;
      full_q    <= full_d;
      rd_data_q <= rd_data_d;
      irq_q     <= |(pending_q & bus.IRQ_EN);
      for (int i = 0; i < CH; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign bus.RD_DATA = rd_data_q;
  assign bus.PENDING = pending_q;
  assign bus.FULL    = full_q;
  assign bus.OVF     = ovf_q;
  assign bus.SND_IRQ = irq_q;
endmodule

// File: tb/tb_toaplan2_snd_mailbox.sv
// Directed bench: a FIFO-mode and a latch-mode mailbox share one stimulus stream;
// each section checks the instance it targets against hand-computed values.
module tb_toaplan2_snd_mailbox;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0, rd = 1'b0;
  logic       wr_ch = 1'b0, rd_ch = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [1:0] ovf_clr = 2'b00, irq_en = 2'b00;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] exp_head;

  always #5 clk = ~clk;

  toaplan2_snd_mailbox_if #(.CH(2), .DW(8)) bus_f ();
  toaplan2_snd_mailbox_if #(.CH(2), .DW(8)) bus_l ();

  assign bus_f.WR = wr;           assign bus_l.WR = wr;
  assign bus_f.WR_CH = wr_ch;     assign bus_l.WR_CH = wr_ch;
  assign bus_f.WR_DATA = wr_data; assign bus_l.WR_DATA = wr_data;
  assign bus_f.RD = rd;           assign bus_l.RD = rd;
  assign bus_f.RD_CH = rd_ch;     assign bus_l.RD_CH = rd_ch;
  assign bus_f.OVF_CLR = ovf_clr; assign bus_l.OVF_CLR = ovf_clr;
  assign bus_f.IRQ_EN = irq_en;   assign bus_l.IRQ_EN = irq_en;

  toaplan2_snd_mailbox #(.CH(2), .DEPTH(4), .DW(8), .FIFO_MODE(1)) dut_fifo (
    .CLK96(clk), .RESET96(rst), .bus(bus_f)
  );
  toaplan2_snd_mailbox #(.CH(2), .DEPTH(4), .DW(8), .FIFO_MODE(0)) dut_latch (
    .CLK96(clk), .RESET96(rst), .bus(bus_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ch, input logic [7:0] d);
    wr_ch = ch; wr_data = d; wr = 1'b1;
    step();
    wr = 1'b0;
    step();
  endtask

  task automatic pop(input logic ch);
    rd_ch = ch; rd = 1'b1;
    step();
    rd = 1'b0;
    step();
  endtask

  task automatic both(input logic ch, input logic [7:0] d);
    wr_ch = ch; rd_ch = ch; wr_data = d; wr = 1'b1; rd = 1'b1;
    step();
    wr = 1'b0; rd = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    // Reset and idle
    do_reset();
    repeat (10) step();
    check("idle_rd_data", 32'(bus_f.RD_DATA), 'h0);
    check("idle_pending", 32'(bus_f.PENDING), 'h0);
    check("idle_full",    32'(bus_f.FULL),    'h0);
    check("idle_ovf",     32'(bus_f.OVF),     'h0);
    check("idle_irq",     32'(bus_f.SND_IRQ), 'h0);

    // Long WR gives exactly one push
    wr_ch = 1'b0; wr_data = 8'hA5; wr = 1'b1;
    repeat (6) step();
    wr = 1'b0;
    step();
    check("long_wr_pending", 32'(bus_f.PENDING), 'h1);
    pop(1'b0);
    check("long_wr_data",    32'(bus_f.RD_DATA), 'hA5);
    check("long_wr_empty",   32'(bus_f.PENDING), 'h0);

    // Overflow on channel 1, drain, empty pop
    push(1'b1, 8'h11); push(1'b1, 8'h22); push(1'b1, 8'h33);
    push(1'b1, 8'h44); push(1'b1, 8'h55);
    check("ovf_full",    32'(bus_f.FULL),    'h2);
    check("ovf_set",     32'(bus_f.OVF),     'h2);
    check("ovf_pending", 32'(bus_f.PENDING), 'h2);
    pop(1'b1); check("pop1", 32'(bus_f.RD_DATA), 'h11);
    check("pop1_full", 32'(bus_f.FULL), 'h0);
    pop(1'b1); check("pop2", 32'(bus_f.RD_DATA), 'h22);
    pop(1'b1); check("pop3", 32'(bus_f.RD_DATA), 'h33);
    pop(1'b1); check("pop4", 32'(bus_f.RD_DATA), 'h44);
    check("pop4_pending", 32'(bus_f.PENDING), 'h0);
    pop(1'b1);
    check("empty_pop_data",    32'(bus_f.RD_DATA), 'h44);
    check("empty_pop_pending", 32'(bus_f.PENDING), 'h0);
    ovf_clr = 2'b10; step(); ovf_clr = 2'b00;
    check("ovf_clr", 32'(bus_f.OVF), 'h0);

    // Full channel with simultaneous push/pop, across pointer wrap
    q.delete();
    for (int k = 0; k < 4; k++) begin
      push(1'b1, 8'(8'h60 + k));
      q.push_back(8'(8'h60 + k));
    end
    for (int k = 0; k < 10; k++) begin
      both(1'b1, 8'(8'h70 + k));
      exp_head = q.pop_front();
      q.push_back(8'(8'h70 + k));
      check($sformatf("pp_data_%0d", k), 32'(bus_f.RD_DATA), 32'(exp_head));
      check($sformatf("pp_full_%0d", k), 32'(bus_f.FULL[1]), 'h1);
      check($sformatf("pp_ovf_%0d", k),  32'(bus_f.OVF[1]),  'h0);
    end
    for (int k = 0; k < 4; k++) begin
      pop(1'b1);
      exp_head = q.pop_front();
      check($sformatf("drain_%0d", k), 32'(bus_f.RD_DATA), 32'(exp_head));
    end
    check("drain_pending", 32'(bus_f.PENDING), 'h0);

    // Latch mode
    do_reset();
    push(1'b0, 8'h01); push(1'b0, 8'h02);
    check("lat_ovf",     32'(bus_l.OVF),     'h1);
    check("lat_pending", 32'(bus_l.PENDING), 'h1);
    check("lat_full",    32'(bus_l.FULL),    'h1);
    pop(1'b0);
    check("lat_pop_data",  32'(bus_l.RD_DATA), 'h02);
    check("lat_pop_empty", 32'(bus_l.PENDING), 'h0);
    ovf_clr = 2'b01; step(); ovf_clr = 2'b00;
    check("lat_ovf_clr", 32'(bus_l.OVF), 'h0);
    push(1'b0, 8'h03);
    ovf_clr = 2'b01; wr_data = 8'h04; wr = 1'b1;
    step();
    ovf_clr = 2'b00; wr = 1'b0;
    check("lat_set_wins", 32'(bus_l.OVF), 'h1);
    step();
    ovf_clr = 2'b01; step(); ovf_clr = 2'b00;
    both(1'b0, 8'h05);
    check("lat_pp_data",    32'(bus_l.RD_DATA), 'h04);
    check("lat_pp_pending", 32'(bus_l.PENDING), 'h1);
    check("lat_pp_ovf",     32'(bus_l.OVF),     'h0);
    pop(1'b0);
    check("lat_pop2_data",  32'(bus_l.RD_DATA), 'h05);

    // Interrupt masking and latency
    do_reset();
    irq_en = 2'b10;
    push(1'b0, 8'h0C);
    check("irq_masked", 32'(bus_f.SND_IRQ), 'h0);
    wr_ch = 1'b1; wr_data = 8'h0D; wr = 1'b1;
    step();
    check("irq_t0", 32'(bus_f.SND_IRQ), 'h0);
    step();
    check("irq_t1", 32'(bus_f.SND_IRQ), 'h1);
    wr = 1'b0;
    step();
    rd_ch = 1'b1; rd = 1'b1;
    step();
    check("irq_pop_t0", 32'(bus_f.SND_IRQ), 'h1);
    step();
    check("irq_pop_t1", 32'(bus_f.SND_IRQ), 'h0);
    rd = 1'b0;
    step();

    // Asynchronous reset during a held WR
    do_reset();
    irq_en = 2'b00;
    push(1'b0, 8'hC0); push(1'b0, 8'hC1); push(1'b0, 8'hC2); push(1'b0, 8'hC3);
    pop(1'b0);
    check("pre_rst_data", 32'(bus_f.RD_DATA), 'hC0);
    wr_ch = 1'b0; wr_data = 8'hB7; wr = 1'b1;
    step();
    check("pre_rst_full", 32'(bus_f.FULL), 'h1);
    #2 rst = 1'b1;
    #1;
    check("async_pending", 32'(bus_f.PENDING), 'h0);
    check("async_full",    32'(bus_f.FULL),    'h0);
    check("async_rd_data", 32'(bus_f.RD_DATA), 'h0);
    step();
    step();
    #3 rst = 1'b0;
    repeat (3) step();
    wr = 1'b0;
    step();
    check("rel_pending", 32'(bus_f.PENDING), 'h1);
    check("rel_full",    32'(bus_f.FULL),    'h0);
    pop(1'b0);
    check("rel_data",  32'(bus_f.RD_DATA), 'hB7);
    check("rel_empty", 32'(bus_f.PENDING), 'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
